// File: rtl/wsi_burst_source.sv
// rtl/wsi_burst_source.sv - WSI precise write-burst source with LFSR data and SThreadBusy backpressure
module wsi_burst_source #(
  parameter logic [31:0] SEED       = 32'h0000_0001,
  parameter int          MAX_BURST  = 16,
  parameter int          GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [2:0]  wsi_MCmd,
  output logic        wsi_MReqLast,
  output logic        wsi_MBurstPrecise,
  output logic [11:0] wsi_MBurstLength,
  output logic [31:0] wsi_MData,
  output logic [3:0]  wsi_MByteEn,
  output logic [7:0]  wsi_MReqInfo,
  input  logic        wsi_SThreadBusy,
  output logic        wsi_MReset_n,
  output logic [15:0] bursts_sent,
  output logic [15:0] words_sent
);

  localparam logic [2:0]  CMD_WR    = 3'b001;
  localparam logic [2:0]  CMD_IDLE  = 3'b000;
  localparam logic [31:0] SEED_INIT = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [11:0] LEN_MASK  = 12'(MAX_BURST - 1);
  localparam logic [3:0]  GAP_LAST  = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t      state, state_nxt;
  logic [31:0] lfsr, lfsr_nxt, lfsr_adv;
  logic [11:0] rem, rem_nxt, len;
  logic [3:0]  gap_cnt, gap_cnt_nxt;
  logic        accept;

  logic [2:0]  cmd_nxt;
  logic        last_nxt, precise_nxt, mreset_n_nxt;
  logic [11:0] blen_nxt;
  logic [31:0] data_nxt;
  logic [3:0]  be_nxt;
  logic [7:0]  info_nxt;
  logic [15:0] bursts_nxt, words_nxt;

  assign lfsr_adv = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
  assign len      = (lfsr[11:0] & LEN_MASK) + 12'd1;
  assign accept   = (wsi_MCmd == CMD_WR) && !wsi_SThreadBusy;

  always_comb begin
    state_nxt    = state;
    lfsr_nxt     = lfsr;
    rem_nxt      = rem;
    gap_cnt_nxt  = gap_cnt;
    cmd_nxt      = wsi_MCmd;
    last_nxt     = wsi_MReqLast;
    precise_nxt  = wsi_MBurstPrecise;
    blen_nxt     = wsi_MBurstLength;
    data_nxt     = wsi_MData;
    be_nxt       = wsi_MByteEn;
    info_nxt     = wsi_MReqInfo;
    bursts_nxt   = bursts_sent;
    words_nxt    = words_sent;
    mreset_n_nxt = 1'b1;
    case (state)
      IDLE: begin
        if (wsi_MReset_n && enable) begin
          state_nxt   = BURST;
          cmd_nxt     = CMD_WR;
          be_nxt      = 4'hF;
          precise_nxt = 1'b1;
          blen_nxt    = len;
          rem_nxt     = len;
          data_nxt    = lfsr;
          info_nxt    = bursts_sent[7:0];
          last_nxt    = (len == 12'd1);
        end
      end
      BURST: begin
        // Nothing moves while the slave is busy, so every output holds.
        if (accept) begin
          words_nxt = words_sent + 16'd1;
          lfsr_nxt  = lfsr_adv;
          if (rem == 12'd1) begin
            bursts_nxt  = bursts_sent + 16'd1;
            cmd_nxt     = CMD_IDLE;
            be_nxt      = 4'h0;
            last_nxt    = 1'b0;
            precise_nxt = 1'b0;
            blen_nxt    = 12'd0;
            gap_cnt_nxt = 4'd0;
            state_nxt   = (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            data_nxt = lfsr_adv;
            rem_nxt  = rem - 12'd1;
            last_nxt = (rem == 12'd2);
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
        else                     gap_cnt_nxt = gap_cnt + 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      lfsr              <= SEED_INIT;
      rem               <= 12'd0;
      gap_cnt           <= 4'd0;
      wsi_MCmd          <= CMD_IDLE;
      wsi_MReqLast      <= 1'b0;
      wsi_MBurstPrecise <= 1'b0;
      wsi_MBurstLength  <= 12'd0;
      wsi_MData         <= 32'd0;
      wsi_MByteEn       <= 4'h0;
      wsi_MReqInfo      <= 8'd0;
      wsi_MReset_n      <= 1'b0;
      bursts_sent       <= 16'd0;
      words_sent        <= 16'd0;
    end else begin
      state             <= state_nxt;
      lfsr              <= lfsr_nxt;
      rem               <= rem_nxt;
      gap_cnt           <= gap_cnt_nxt;
      wsi_MCmd          <= cmd_nxt;
      wsi_MReqLast      <= last_nxt;
      wsi_MBurstPrecise <= precise_nxt;
      wsi_MBurstLength  <= blen_nxt;
      wsi_MData         <= data_nxt;
      wsi_MByteEn       <= be_nxt;
      wsi_MReqInfo      <= info_nxt;
      wsi_MReset_n      <= mreset_n_nxt;
      bursts_sent       <= bursts_nxt;
      words_sent        <= words_nxt;
    end
  end

endmodule
